// File: rtl/quad_detent_counter.sv
// Quadrature decoder and detent counter that feeds the calculator FSM operand/operator value.
// Optional step acceleration is built when QUAD_ACCEL_EN is defined.
module quad_detent_counter #(
  parameter int WIDTH            = 8,
  parameter int STEPS_PER_DETENT = 4,
  parameter int MAX_VAL          = 255,
  parameter int WRAP             = 1,
  parameter int ACCEL_WINDOW     = 16,
  parameter int ACCEL_STEP       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_i,
  input  logic             b_i,
  input  logic             clear_i,
  input  logic             hold_i,
  output logic [WIDTH-1:0] count_o,
  output logic             up_pulse_o,
  output logic             down_pulse_o,
  output logic             err_pulse_o
);

  localparam int ACC_W = $clog2(STEPS_PER_DETENT) + 2;
  localparam logic signed [ACC_W-1:0] ACC_ONE = ACC_W'(1);
  localparam logic signed [ACC_W-1:0] ACC_TOP = ACC_W'(STEPS_PER_DETENT - 1);
  localparam logic signed [ACC_W-1:0] ACC_BOT = -ACC_TOP;
  localparam logic [WIDTH:0] LIM_X  = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0] SPAN_X = (WIDTH+1)'(MAX_VAL + 1);
  localparam logic [WIDTH:0] ONE_X  = (WIDTH+1)'(1);

  if (STEPS_PER_DETENT != 1 && STEPS_PER_DETENT != 2 && STEPS_PER_DETENT != 4) begin : g_bad_steps
    $error("quad_detent_counter: STEPS_PER_DETENT must be 1, 2 or 4");
  end
  if (MAX_VAL < 1 || MAX_VAL > (1 << WIDTH) - 1) begin : g_bad_max
    $error("quad_detent_counter: MAX_VAL out of range for WIDTH");
  end
  if (ACCEL_STEP < 1 || ACCEL_STEP > MAX_VAL + 1 || ACCEL_WINDOW < 1) begin : g_bad_accel
    $error("quad_detent_counter: ACCEL_STEP/ACCEL_WINDOW out of range");
  end

  logic [1:0]              a_sync_q, b_sync_q, prev_q, fill_q, s, diff;
  logic                    primed_q, tr_up_q, tr_dn_q, tr_err_q;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]        count_q, count_d, nxt_up, nxt_dn;
  logic                    up_q, up_d, dn_q, dn_d, err_q, err_d;
  logic                    step_up, step_dn;
  logic [WIDTH:0]          cnt_x, sum_up_x, mv_up_x, mv_dn_x;

  // Position along the up sequence 00->10->11->01, so a legal move is +/-1 mod 4.
  function automatic logic [1:0] phase(input logic [1:0] ab);
    case (ab)
      2'b00:   phase = 2'd0;
      2'b10:   phase = 2'd1;
      2'b11:   phase = 2'd2;
      default: phase = 2'd3;
    endcase
  endfunction

  assign s    = {a_sync_q[1], b_sync_q[1]};
  assign diff = phase(s) - phase(prev_q);

`ifdef QUAD_ACCEL_EN
  localparam int GAP_W = $clog2(ACCEL_WINDOW + 1);
  localparam logic [GAP_W-1:0] GAP_MAX    = GAP_W'(ACCEL_WINDOW);
  localparam logic [WIDTH:0]   ACC_STEP_X = (WIDTH+1)'(ACCEL_STEP);

  logic [GAP_W-1:0] gap_q;
  logic             last_up_q;
  logic             fast;

  assign fast    = (gap_q < GAP_MAX);
  assign mv_up_x = (fast && last_up_q)  ? ACC_STEP_X : ONE_X;
  assign mv_dn_x = (fast && !last_up_q) ? ACC_STEP_X : ONE_X;

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      gap_q     <= GAP_MAX;
      last_up_q <= 1'b0;
    end else if (step_up || step_dn) begin
      gap_q     <= '0;
      last_up_q <= step_up;
    end else if (gap_q != GAP_MAX) begin
      gap_q <= gap_q + 1'b1;
    end
  end
`else
  assign mv_up_x = ONE_X;
  assign mv_dn_x = ONE_X;
`endif

  assign cnt_x    = {1'b0, count_q};
  assign sum_up_x = cnt_x + mv_up_x;

  // Limit handling is done one bit wider so MAX_VAL+1 and the full move fit.
  always_comb begin
    if (sum_up_x > LIM_X) nxt_up = (WRAP != 0) ? WIDTH'(sum_up_x - SPAN_X) : WIDTH'(LIM_X);
    else                  nxt_up = WIDTH'(sum_up_x);
    if (mv_dn_x > cnt_x)  nxt_dn = (WRAP != 0) ? WIDTH'(cnt_x + SPAN_X - mv_dn_x) : '0;
    else                  nxt_dn = WIDTH'(cnt_x - mv_dn_x);
  end

  always_comb begin
    acc_d   = acc_q;
    count_d = count_q;
    step_up = 1'b0;
    step_dn = 1'b0;
    if (clear_i) begin
      acc_d   = '0;
      count_d = '0;
    end else if (hold_i || tr_err_q) begin
      acc_d = '0;
    end else if (tr_up_q) begin
      if (acc_q == ACC_TOP) begin
        acc_d   = '0;
        step_up = 1'b1;
        count_d = nxt_up;
      end else begin
        acc_d = acc_q + ACC_ONE;
      end
    end else if (tr_dn_q) begin
      if (acc_q == ACC_BOT) begin
        acc_d   = '0;
        step_dn = 1'b1;
        count_d = nxt_dn;
      end else begin
        acc_d = acc_q - ACC_ONE;
      end
    end
    up_d  = step_up;
    dn_d  = step_dn;
    err_d = tr_err_q;
  end

  // Priming waits for the synchronizer to fill so reset-time zeros never look like a move.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sync_q <= '0;
      b_sync_q <= '0;
      fill_q   <= '0;
      primed_q <= 1'b0;
      prev_q   <= '0;
      tr_up_q  <= 1'b0;
      tr_dn_q  <= 1'b0;
      tr_err_q <= 1'b0;
      acc_q    <= '0;
      count_q  <= '0;
      up_q     <= 1'b0;
      dn_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      a_sync_q <= {a_sync_q[0], a_i};
      b_sync_q <= {b_sync_q[0], b_i};
      fill_q   <= {fill_q[0], 1'b1};
      primed_q <= fill_q[1];
      prev_q   <= s;
      tr_up_q  <= primed_q && (diff == 2'd1);
      tr_dn_q  <= primed_q && (diff == 2'd3);
      tr_err_q <= primed_q && (diff == 2'd2);
      acc_q    <= acc_d;
      count_q  <= count_d;
      up_q     <= up_d;
      dn_q     <= dn_d;
      err_q    <= err_d;
    end
  end

  assign count_o      = count_q;
  assign up_pulse_o   = up_q;
  assign down_pulse_o = dn_q;
  assign err_pulse_o  = err_q;

endmodule

// File: doc/quad_detent_counter.md
Name: quad_detent_counter

Overview:
- Quadrature decoder and value counter that sits directly upstream of the calculator FSM.
- Takes debounced rotary A/B lines and produces the WIDTH-bit operand/operator value the FSM latches.
- Counts one step per mechanical detent, with wrap or saturate at the range limits.
- Emits per-step direction pulses and an illegal-transition error pulse.

Parameters:
- WIDTH, 8, counter width in bits.
- STEPS_PER_DETENT, 4, quadrature transitions per count step. Legal values are 1, 2 and 4.
- MAX_VAL, 255, upper count limit, inclusive. Must be ≤ 2^WIDTH-1. Lower limit is 0.
- WRAP, 1, 1 = wrap around at the limits, 0 = saturate at the limits.
- ACCEL_WINDOW, 16, cycles; used only by the optional feature.
- ACCEL_STEP, 4, increment per accelerated step; used only by the optional feature.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- a  in  1  rotary channel A, debounced, asynchronous to clk
- b  in  1  rotary channel B, debounced, asynchronous to clk
- clear  in  1  synchronous clear of count to 0
- hold  in  1  freeze; transitions are tracked but not counted
- count  out  WIDTH  current value, registered
- up_pulse  out  1  1-cycle pulse on each count increment
- down_pulse  out  1  1-cycle pulse on each count decrement
- err_pulse  out  1  1-cycle pulse on an illegal transition

Behaviour:
- Reset values:
  - count = 0; up_pulse, down_pulse, err_pulse = 0.
  - Sub-step accumulator = 0; primed = 0.
  - Both 2-FF synchronizer stages = 0.
- Synchronization: a and b each pass through a 2-FF synchronizer. s = {a_sync, b_sync}. prev holds s from the previous cycle.
- Priming: the first cycle after reset only loads prev := s and sets primed. No step or error is generated in that cycle. This prevents a spurious step when the inputs rest at non-zero levels.
- Transition decode, evaluated every primed cycle:
  - Up (A leads): 00→10→11→01→00 gives +1 transition.
  - Down: the reverse sequence gives -1 transition.
  - s == prev: no action.
  - Both bits changed: illegal. err_pulse = 1 next cycle; accumulator is cleared; count is unchanged.
- Accumulator: signed, range ±STEPS_PER_DETENT.
  - Reaching +STEPS_PER_DETENT issues one increment; accumulator resets to 0.
  - Reaching -STEPS_PER_DETENT issues one decrement; accumulator resets to 0.
  - A direction reversal mid-detent simply moves the accumulator back toward 0.
- Latency: an edge on a or b sampled at edge k is counted, and count/pulse become visible, after edge k+3.
- Increment at the upper limit: count = MAX_VAL goes to 0 if WRAP = 1, otherwise stays at MAX_VAL. up_pulse fires in both cases.
- Decrement at the lower limit: count = 0 goes to MAX_VAL if WRAP = 1, otherwise stays at 0. down_pulse fires in both cases.
- Pulses: the three pulses are mutually exclusive and each lasts exactly 1 cycle.
- hold = 1:
  - prev is still updated every cycle.
  - Accumulator is held at 0.
  - No count change and no up/down pulse.
  - err_pulse is still reported.
- clear:
  - Sets count = 0 and accumulator = 0 next edge.
  - Overrides a simultaneous step; that step's pulse is suppressed.
  - Works during hold.
- Priority: rst > clear > hold > step.
- rst mid-detent: accumulator is lost, primed is cleared, and the priming rule applies again.

Optional Feature:
- Macro: QUAD_ACCEL_EN.
- Defined:
  - A free-running gap counter (saturating at ACCEL_WINDOW) restarts on every issued step.
  - If a step occurs in the same direction as the previous step and the gap counter < ACCEL_WINDOW, count moves by ACCEL_STEP instead of 1.
  - Wrap/saturate rules apply to the full move. Wrap is modulo MAX_VAL+1; saturate clamps at the limit.
  - Exactly one up/down pulse is issued per step.
  - clear and rst reset the gap counter to ACCEL_WINDOW, i.e. not accelerating.
- Undefined: every step is ±1. The gap logic is absent.

Test Plan:
1. Reset with a = b = 1 held, then idle 10 cycles -> count = 0, no pulses, no err_pulse.
2. One full up detent (00→10→11→01→00, each state held 5 cycles), STEPS_PER_DETENT = 4 -> count 0→1, one up_pulse exactly 3 cycles after the final 01→00 edge.
3. Three down detents from count = 1, WRAP = 1 -> count 1→0→255→254, three down_pulses. Same stimulus with WRAP = 0 -> count goes 0 and stays at 0, three down_pulses.
4. Forced jump 00→11 -> err_pulse for 1 cycle, count unchanged, accumulator cleared. The next full up detent then gives count +1.
5. clear asserted in the same cycle a detent completes at count = 7 -> count = 0, no up_pulse. hold = 1 across two detents -> count unchanged, no pulses.
6. With QUAD_ACCEL_EN defined, ACCEL_WINDOW = 16: two up detents 10 cycles apart starting at count 0 -> count 0→1→5. A third detent 40 cycles later -> count 6.
